// File: rtl/pipe_alu.sv
// pipe_alu - registered WIDTH-bit ALU with status flags, an accumulator and
// optional unsigned saturation, sitting between a valid/ready producer and a
// result consumer.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 4)
//   SAT    1 = ADD/SUB saturate unsigned, 0 = wrap-around
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand transaction offered
//   in_ready   block can accept a transaction this cycle
//   in_a       operand A
//   in_b       operand B (low clog2(WIDTH) bits are the shift amount)
//   in_op      operation select
//                000 AND  001 OR   010 ADD  011 SUB
//                100 XOR  101 SHL  110 SHR  111 SLTU
//   use_acc    operand A taken from the accumulator instead of in_a
//   acc_wr     accumulator loaded with this transaction's result
//   acc_clr    synchronous accumulator clear, independent of handshake
//   out_valid  result register holds an unconsumed result
//   out_ready  consumer accepts the result
//   out_y      result
//   out_flags  {N, Z, C, V}
//   acc_q      current accumulator value

module pipe_alu #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             use_acc,
    input  logic             acc_wr,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [3:0]       out_flags,
    output logic [WIDTH-1:0] acc_q
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    logic             accept;
    logic [WIDTH-1:0] a_op;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_v;
    logic             sub_v;
    logic [WIDTH-1:0] res;
    logic             c_flag;
    logic             v_flag;
    logic             n_flag;
    logic             z_flag;

    // Back-pressure passes straight through: a slot frees up in the same
    // cycle the consumer takes the held result.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign a_op = use_acc ? acc_q : in_a;
    assign sh   = in_b[SHW-1:0];

    // One extra bit carries the ADD carry-out / SUB borrow.
    assign sum  = {1'b0, a_op} + {1'b0, in_b};
    assign diff = {1'b0, a_op} - {1'b0, in_b};

    assign add_v = (a_op[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1]  != a_op[WIDTH-1]);
    assign sub_v = (a_op[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != a_op[WIDTH-1]);

    always_comb begin
        res    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        unique case (in_op)
            OP_AND:  res = a_op & in_b;
            OP_OR:   res = a_op | in_b;
            OP_ADD: begin
                c_flag = sum[WIDTH];
                v_flag = add_v;
                // C and V keep reporting the raw condition when clamped.
                res    = (SAT && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
            end
            OP_SUB: begin
                c_flag = diff[WIDTH];
                v_flag = sub_v;
                res    = (SAT && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
            end
            OP_XOR:  res = a_op ^ in_b;
            OP_SHL:  res = a_op << sh;
            OP_SHR:  res = a_op >> sh;
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
            default: res = '0;
        endcase
    end

    assign n_flag = res[WIDTH-1];
    assign z_flag = (res == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_flags <= 4'b0000;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_y     <= res;
            out_flags <= {n_flag, z_flag, c_flag, v_flag};
        end else if (out_ready) begin
            // Delivered with nothing new behind it: data keeps its last value.
            out_valid <= 1'b0;
        end
    end

    // Clear wins over a simultaneous accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (acc_clr) begin
            acc_q <= '0;
        end else if (accept && acc_wr) begin
            acc_q <= res;
        end
    end

endmodule

// File: tb/tb_pipe_alu.sv
module tb_pipe_alu;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       use_acc;
    logic       acc_wr;
    logic       acc_clr;
    logic       out_ready;

    logic       rdy0, vld0, rdy1, vld1;
    logic [7:0] y0, y1, acc0, acc1;
    logic [3:0] f0, f1;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_alu #(.WIDTH(8), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .use_acc(use_acc),
        .acc_wr(acc_wr), .acc_clr(acc_clr), .out_valid(vld0),
        .out_ready(out_ready), .out_y(y0), .out_flags(f0), .acc_q(acc0)
    );

    pipe_alu #(.WIDTH(8), .SAT(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .use_acc(use_acc),
        .acc_wr(acc_wr), .acc_clr(acc_clr), .out_valid(vld1),
        .out_ready(out_ready), .out_y(y1), .out_flags(f1), .acc_q(acc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one transaction, let it be accepted on the next edge, then idle.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ua, input logic aw);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        use_acc  = ua;
        acc_wr   = aw;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        use_acc  = 1'b0;
        acc_wr   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 3'b000;
        use_acc = 1'b0; acc_wr = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (vld0 !== 1'b0)    begin n_fail++; $display("FAIL reset_valid: got %b expected 0", vld0); end
        n_checks++; if (y0 !== 8'h00)     begin n_fail++; $display("FAIL reset_y: got %h expected 00", y0); end
        n_checks++; if (f0 !== 4'b0000)   begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", f0); end
        n_checks++; if (acc0 !== 8'h00)   begin n_fail++; $display("FAIL reset_acc: got %h expected 00", acc0); end
        n_checks++; if (rdy0 !== 1'b1)    begin n_fail++; $display("FAIL reset_ready: got %b expected 1", rdy0); end
    endtask

    task automatic test_ops();
        logic [2:0] ops [10] = '{3'b010, 3'b011, 3'b010, 3'b111, 3'b101,
                                 3'b000, 3'b001, 3'b100, 3'b110, 3'b010};
        logic [7:0] as  [10] = '{8'hF0, 8'h10, 8'h7F, 8'h03, 8'h81,
                                 8'hF0, 8'hF0, 8'hAA, 8'h80, 8'hFF};
        logic [7:0] bs  [10] = '{8'h20, 8'h20, 8'h01, 8'h05, 8'h09,
                                 8'h3C, 8'h0F, 8'hAA, 8'h07, 8'h01};
        logic [7:0] ey  [10] = '{8'h10, 8'hF0, 8'h80, 8'h01, 8'h02,
                                 8'h30, 8'hFF, 8'h00, 8'h01, 8'h00};
        logic [3:0] ef  [10] = '{4'b0010, 4'b1010, 4'b1001, 4'b0000, 4'b0000,
                                 4'b0000, 4'b1000, 4'b0100, 4'b0000, 4'b0110};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(ops[i], as[i], bs[i], 1'b0, 1'b0);
            n_checks++; if (vld0 !== 1'b1) begin n_fail++; $display("FAIL ops_valid[%0d]: got %b expected 1", i, vld0); end
            n_checks++; if (y0 !== ey[i])  begin n_fail++; $display("FAIL ops_y[%0d]: got %h expected %h", i, y0, ey[i]); end
            n_checks++; if (f0 !== ef[i])  begin n_fail++; $display("FAIL ops_flags[%0d]: got %b expected %b", i, f0, ef[i]); end
        end
    endtask

    task automatic test_sat();
        logic [2:0] ops [4] = '{3'b010, 3'b011, 3'b011, 3'b010};
        logic [7:0] as  [4] = '{8'hF0, 8'h10, 8'h20, 8'hFF};
        logic [7:0] bs  [4] = '{8'h20, 8'h20, 8'h10, 8'h01};
        logic [7:0] ey  [4] = '{8'hFF, 8'h00, 8'h10, 8'hFF};
        logic [3:0] ef  [4] = '{4'b1010, 4'b0110, 4'b0000, 4'b1010};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(ops[i], as[i], bs[i], 1'b0, 1'b0);
            n_checks++; if (y1 !== ey[i]) begin n_fail++; $display("FAIL sat_y[%0d]: got %h expected %h", i, y1, ey[i]); end
            n_checks++; if (f1 !== ef[i]) begin n_fail++; $display("FAIL sat_flags[%0d]: got %b expected %b", i, f1, ef[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] as [4] = '{8'h01, 8'h04, 8'h10, 8'h22};
        logic [7:0] bs [4] = '{8'h02, 8'h04, 8'h01, 8'h11};
        logic [7:0] ey [4] = '{8'h03, 8'h08, 8'h11, 8'h33};
        out_ready = 1'b1;
        in_op = 3'b010; use_acc = 1'b0; acc_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = as[i]; in_b = bs[i];
            @(posedge clk); #1;
            n_checks++; if (vld0 !== 1'b1)  begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, vld0); end
            n_checks++; if (y0 !== ey[i])   begin n_fail++; $display("FAIL b2b_y[%0d]: got %h expected %h", i, y0, ey[i]); end
            n_checks++; if (rdy0 !== 1'b1)  begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, rdy0); end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (vld0 !== 1'b0)  begin n_fail++; $display("FAIL b2b_drain_valid: got %b expected 0", vld0); end
        n_checks++; if (y0 !== 8'h33)   begin n_fail++; $display("FAIL b2b_drain_hold: got %h expected 33", y0); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        send(3'b010, 8'h01, 8'h01, 1'b0, 1'b0);
        n_checks++; if (y0 !== 8'h02) begin n_fail++; $display("FAIL bp_first: got %h expected 02", y0); end
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'b010; in_a = 8'h03; in_b = 8'h04;
        #1;
        n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b expected 0", rdy0); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++; if (vld0 !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, vld0); end
            n_checks++; if (y0 !== 8'h02)  begin n_fail++; $display("FAIL bp_hold_y[%0d]: got %h expected 02", i, y0); end
            n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready[%0d]: got %b expected 0", i, rdy0); end
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", rdy0); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (vld0 !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b expected 1", vld0); end
        n_checks++; if (y0 !== 8'h07)  begin n_fail++; $display("FAIL bp_next_y: got %h expected 07", y0); end
        @(posedge clk); #1;
        n_checks++; if (vld0 !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b expected 0", vld0); end
    endtask

    task automatic test_acc();
        out_ready = 1'b1;
        send(3'b010, 8'h05, 8'h00, 1'b0, 1'b1);
        n_checks++; if (acc0 !== 8'h05) begin n_fail++; $display("FAIL acc_load: got %h expected 05", acc0); end
        send(3'b010, 8'hEE, 8'h03, 1'b1, 1'b1);
        n_checks++; if (acc0 !== 8'h08) begin n_fail++; $display("FAIL acc_add1: got %h expected 08", acc0); end
        n_checks++; if (y0 !== 8'h08)   begin n_fail++; $display("FAIL acc_add1_y: got %h expected 08", y0); end
        send(3'b010, 8'hEE, 8'h03, 1'b1, 1'b1);
        n_checks++; if (acc0 !== 8'h0B) begin n_fail++; $display("FAIL acc_add2: got %h expected 0b", acc0); end
        acc_clr = 1'b1;
        send(3'b010, 8'hEE, 8'h03, 1'b1, 1'b1);
        acc_clr = 1'b0;
        n_checks++; if (acc0 !== 8'h00) begin n_fail++; $display("FAIL acc_clr_wins: got %h expected 00", acc0); end
        n_checks++; if (y0 !== 8'h0E)   begin n_fail++; $display("FAIL acc_clr_y: got %h expected 0e", y0); end
        send(3'b010, 8'h09, 8'h00, 1'b0, 1'b1);
        in_a = 8'h55; acc_wr = 1'b1;
        @(posedge clk); #1;
        acc_wr = 1'b0;
        n_checks++; if (acc0 !== 8'h09) begin n_fail++; $display("FAIL acc_wr_no_accept: got %h expected 09", acc0); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send(3'b010, 8'h7F, 8'h01, 1'b0, 1'b1);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'b010; in_a = 8'h11; in_b = 8'h11;
        @(posedge clk); #1;
        n_checks++; if (vld0 !== 1'b1 || f0 !== 4'b1001) begin n_fail++; $display("FAIL rstmid_pre: got valid %b flags %b expected 1 1001", vld0, f0); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (vld0 !== 1'b0)  begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", vld0); end
        n_checks++; if (acc0 !== 8'h00) begin n_fail++; $display("FAIL rstmid_acc: got %h expected 00", acc0); end
        n_checks++; if (f0 !== 4'b0000) begin n_fail++; $display("FAIL rstmid_flags: got %b expected 0000", f0); end
        n_checks++; if (y0 !== 8'h00)   begin n_fail++; $display("FAIL rstmid_y: got %h expected 00", y0); end
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'b010, 8'h02, 8'h03, 1'b0, 1'b0);
        n_checks++; if (vld0 !== 1'b1 || y0 !== 8'h05 || f0 !== 4'b0000)
            begin n_fail++; $display("FAIL rstmid_after: got valid %b y %h flags %b expected 1 05 0000", vld0, y0, f0); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_sat();
        test_back_to_back();
        test_backpressure();
        test_acc();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
